// File: rtl/bus_arbiter_if.sv
// Bundles the two-master request side and the single-slave side of bus_arbiter.
// slave: the arbiter's view. master: the environment (core masters plus memory slave).
interface bus_arbiter_if;
    logic [1:0]  m_req_i;
    logic [1:0]  m_we_i;
    logic [59:0] m_addr_i;
    logic [63:0] m_wdata_i;
    logic [7:0]  m_mask_i;
    logic [1:0]  m_ack_o;
    logic [31:0] m_rdata_o;
    logic [1:0]  m_err_o;
    logic        s_req_o;
    logic        s_we_o;
    logic [29:0] s_addr_o;
    logic [31:0] s_wdata_o;
    logic [3:0]  s_mask_o;
    logic        s_ack_i;
    logic [31:0] s_rdata_i;
    logic        s_err_i;
    logic [1:0]  grant_o;

    modport slave (
        input  m_req_i, m_we_i, m_addr_i, m_wdata_i, m_mask_i, s_ack_i, s_rdata_i, s_err_i,
        output m_ack_o, m_rdata_o, m_err_o, s_req_o, s_we_o, s_addr_o, s_wdata_o, s_mask_o,
               grant_o
    );

    modport master (
        output m_req_i, m_we_i, m_addr_i, m_wdata_i, m_mask_i, s_ack_i, s_rdata_i, s_err_i,
        input  m_ack_o, m_rdata_o, m_err_o, s_req_o, s_we_o, s_addr_o, s_wdata_o, s_mask_o,
               grant_o
    );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master (fetch / data) to one-slave bus arbiter, one transaction outstanding.
// Define BUS_ARB_TIMEOUT_EN to abort grants that see no s_ack_i within TIMEOUT_CYCLES.
module bus_arbiter #(
    parameter int unsigned PRIO_MODE      = 0,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic          clk,
    input  logic          rst_b,
    bus_arbiter_if.slave  bus
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $fatal(1, "bus_arbiter: TIMEOUT_CYCLES must be in 2..255");
    end

    typedef enum logic [1:0] {StIdle = 2'd0, StGrant0 = 2'd1, StGrant1 = 2'd2} state_e;

    state_e r_state, w_state_nxt;
    logic   r_last_grant, w_last_grant_nxt;
    logic   w_port;
    logic   w_granted;
    logic   w_timeout;

    assign w_granted = (r_state == StGrant0) || (r_state == StGrant1);
    assign w_port    = (r_state == StGrant1);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state      <= StIdle;
            r_last_grant <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_grant_nxt;
        end
    end

`ifdef BUS_ARB_TIMEOUT_EN
    logic [7:0] r_cnt, w_cnt_nxt;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) r_cnt <= 8'd0;
        else        r_cnt <= w_cnt_nxt;
    end

    // Any state change (including into the other grant) restarts the count.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_state_nxt != r_state) w_cnt_nxt = 8'd0;
        else if (w_granted && !bus.s_ack_i) w_cnt_nxt = r_cnt + 8'd1;
    end

    assign w_timeout = w_granted && !bus.s_ack_i && (r_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt      = r_state;
        w_last_grant_nxt = r_last_grant;
        bus.s_req_o      = 1'b0;
        bus.s_we_o       = 1'b0;
        bus.s_addr_o     = '0;
        bus.s_wdata_o    = '0;
        bus.s_mask_o     = '0;
        bus.m_ack_o      = '0;
        bus.m_err_o      = '0;
        bus.m_rdata_o    = '0;
        bus.grant_o      = '0;

        unique case (r_state)
            StIdle: begin
                unique case (bus.m_req_i)
                    2'b01:   w_state_nxt = StGrant0;
                    2'b10:   w_state_nxt = StGrant1;
                    2'b11:   w_state_nxt = (PRIO_MODE == 1 || !r_last_grant) ? StGrant1 : StGrant0;
                    default: w_state_nxt = StIdle;
                endcase
            end
            StGrant0, StGrant1: begin
                bus.s_req_o         = 1'b1;
                bus.s_we_o          = bus.m_we_i[w_port];
                bus.s_addr_o        = w_port ? bus.m_addr_i[59:30]  : bus.m_addr_i[29:0];
                bus.s_wdata_o       = w_port ? bus.m_wdata_i[63:32] : bus.m_wdata_i[31:0];
                bus.s_mask_o        = w_port ? bus.m_mask_i[7:4]    : bus.m_mask_i[3:0];
                bus.grant_o[w_port] = 1'b1;
                if (bus.s_ack_i) begin
                    bus.m_ack_o[w_port] = 1'b1;
                    bus.m_err_o[w_port] = bus.s_err_i;
                    bus.m_rdata_o       = bus.s_rdata_i;
                    w_last_grant_nxt    = w_port;
                    // Hand straight over to a waiting peer; in data-priority mode only
                    // a finishing fetch yields directly.
                    if (bus.m_req_i[!w_port] && (PRIO_MODE == 0 || !w_port)) begin
                        w_state_nxt = w_port ? StGrant0 : StGrant1;
                    end else begin
                        w_state_nxt = StIdle;
                    end
                end else if (w_timeout) begin
                    bus.m_ack_o[w_port] = 1'b1;
                    bus.m_err_o[w_port] = 1'b1;
                    w_state_nxt         = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares one slave-side memory bus between the core's two bus masters: port 0 = instruction fetch, port 1 = data load/store.
- Sits between the core and the memory/peripheral interconnect. One transaction is outstanding at a time.
- Grants are round-robin or fixed data-priority, selected by parameter.
- Routes the slave response back to the granted master, optionally with a watchdog that aborts hung transactions.

Parameters:
- PRIO_MODE, 0, 0 = round-robin; 1 = port 1 (data) always wins ties.
- TIMEOUT_CYCLES, 255, cycles in a GRANT state without s_ack_i before abort; legal range 2..255. Only used with BUS_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- rst_b  in  1  asynchronous active-low reset.
- m_req_i  in  2  per-port request; bit n = port n; held until m_ack_o[n].
- m_we_i  in  2  per-port write enable.
- m_addr_i  in  60  word addresses {port1[29:0], port0[29:0]}.
- m_wdata_i  in  64  write data {port1, port0}.
- m_mask_i  in  8  byte masks {port1[3:0], port0[3:0]}.
- m_ack_o  out  2  one-cycle completion pulse per port.
- m_rdata_o  out  32  read data, valid with m_ack_o (shared by both ports).
- m_err_o  out  2  error flag per port, valid only with the matching m_ack_o bit.
- s_req_o  out  1  slave request.
- s_we_o  out  1  slave write enable.
- s_addr_o  out  30  slave word address.
- s_wdata_o  out  32  slave write data.
- s_mask_o  out  4  slave byte mask.
- s_ack_i  in  1  slave completion pulse.
- s_rdata_i  in  32  slave read data.
- s_err_i  in  1  slave bus error.
- grant_o  out  2  one-hot current grant; 00 when idle (debug/ILA).

Behaviour:
- States: IDLE, GRANT0, GRANT1. State, last_grant and the timeout counter are registered.
- Reset (rst_b low, async): state = IDLE, last_grant = 0, counter = 0. All outputs 0: s_req_o = 0, s_* attributes = 0, m_ack_o = 00, m_err_o = 00, m_rdata_o = 0, grant_o = 00.
- IDLE, one request: go to GRANTn on the next edge.
- IDLE, both requests:
  - PRIO_MODE=0: grant the port != last_grant.
  - PRIO_MODE=1: grant port 1.
- GRANTn outputs:
  - s_req_o = 1, and s_we/addr/wdata/mask_o are muxed combinationally from port n.
  - grant_o[n] = 1.
- Latency: request seen in IDLE at cycle 0 -> s_req_o high at cycle 1. A minimum transaction (s_ack_i at cycle 1) gives m_ack_o[n] at cycle 1.
- s_ack_i in GRANTn (same cycle, combinational response):
  - m_ack_o[n] = 1, m_rdata_o = s_rdata_i, m_err_o[n] = s_err_i.
  - last_grant <= n.
- Next state after s_ack_i in GRANTn:
  - Other port requesting, and (PRIO_MODE=0, or PRIO_MODE=1 with n=0): go directly to the other GRANT state, with no idle bubble.
  - Otherwise, if m_req_i[n] is still high on the ack cycle: go to IDLE. This is the requester's deassert cycle; it must drop req after ack.
  - Otherwise: go to IDLE.
- PRIO_MODE=1, ack in GRANT1 with port 1 re-requesting on the next cycle: port 1 wins again. Port 0 starvation is accepted in this mode.
- Requester dropping m_req_i before ack is a protocol violation. The arbiter holds the grant until s_ack_i, then pulses m_ack_o anyway.
- s_ack_i in IDLE is ignored: no m_ack_o, no state change.
- m_ack_o bits are never both set. m_rdata_o = 0 whenever m_ack_o = 00.
- Reset asserted mid-transaction: the transaction is abandoned and the arbiter returns to the reset state immediately. Any s_ack_i arriving afterwards is ignored per the IDLE rule.

Optional Feature:
- Macro: BUS_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to any GRANT state and increments each cycle in GRANT without s_ack_i.
  - When the count reaches TIMEOUT_CYCLES-1 with no s_ack_i: m_ack_o[n] = 1 and m_err_o[n] = 1, s_req_o drops on the next edge, and state goes to IDLE.
  - A late s_ack_i is ignored.
  - s_ack_i in the timeout cycle takes precedence and is a normal completion.
- Undefined: no counter; GRANT waits indefinitely for s_ack_i.

Test Plan:
- Port 0 only, fetch of addr 0x0000100 with slave ack 3 cycles after s_req_o -> s_addr_o = 0x0000100 and grant_o = 01 during the grant; one m_ack_o = 01 pulse with m_rdata_o = slave data; m_err_o = 00.
- PRIO_MODE=0, both ports request continuously with 1-cycle slave ack -> grants alternate 01,10,01,... with no IDLE cycles between; last_grant is correct after reset (first grant = port 1).
- PRIO_MODE=1, both request, port 1 re-requests every cycle -> port 1 served back-to-back; port 0 served only when port 1 is idle.
- Port 1 write of 0xDEADBEEF, mask 4'b0011, with s_err_i=1 on ack -> s_we_o=1, s_mask_o=0011, s_wdata_o=0xDEADBEEF; m_ack_o=10, m_err_o=10.
- BUS_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never acks -> m_ack_o[0]=m_err_o[0]=1 on the 8th grant cycle; s_req_o low next cycle; a late s_ack_i 5 cycles later produces no m_ack_o.
- rst_b pulsed low mid-GRANT1 (async, between clock edges) -> all outputs 0 immediately; IDLE after release; a subsequent port 0 request is granted normally.
